fifo_write_arbiter: RTL and testbench

Packet-locking round-robin arbiter that shares one `ram_fifo` write port between up to four byte producers, e.g. the D-bus receive path and the local status/ack generator, both feeding the UART transmit FIFO. A requester that wins keeps the grant until it presents its last byte, so frames never interleave in the FIFO. The block applies FIFO backpressure per byte, gates new packets on near-full, and reclaims the grant from a requester that stalls mid-packet. It sits between the producers and the write side of a `ram_fifo` instantiated by the parent.

---
 rtl/fifo_write_arbiter_pkg.sv | 28 ++
 rtl/fifo_write_arbiter_rr_pick.sv | 28 ++
 rtl/fifo_write_arbiter.sv | 116 +++++++++++
 tb/tb_fifo_write_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// rtl/fifo_write_arbiter_pkg.sv - shared encodings and limits for the FIFO write arbiter
package fifo_write_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

  localparam int IDLECNT_W   = 8;
  localparam int NREQ_MIN    = 2;
  localparam int NREQ_MAX    = 4;
  localparam int TIMEOUT_MIN = 1;
  localparam int TIMEOUT_MAX = 255;

  function automatic int clamp_int(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int oh_index(input logic [NREQ_MAX-1:0] oh);
    int idx;
    idx = 0;
    for (int i = NREQ_MAX - 1; i >= 0; i--) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rtl/fifo_write_arbiter_rr_pick.sv - combinational round-robin picker starting after the last winner
module rr_pick
  import fifo_write_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDXW = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic [NREQ-1:0] pick,
  output logic            found
);

  always_comb begin
    logic [IDXW-1:0] idx;
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IDXW'((int'(last) + i) % NREQ);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - packet-locking round-robin arbiter for one FIFO write port
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int c_NREQ          = 2,
  parameter int c_DATAWIDTH     = 8,
  parameter int c_TIMEOUT       = 255,
  parameter int c_GATE_NEARFULL = 1
) (
  input  logic                          i_clock,
  input  logic                          i_reset_n,
  input  logic [c_NREQ-1:0]             i_req_valid,
  input  logic [c_NREQ-1:0]             i_req_last,
  input  logic [c_NREQ*c_DATAWIDTH-1:0] i_req_data,
  output logic [c_NREQ-1:0]             o_req_ready,
  output logic                          o_fifo_writeen,
  output logic [c_DATAWIDTH-1:0]        o_fifo_data,
  input  logic                          i_fifo_full,
  input  logic                          i_fifo_nearfull,
  output logic [c_NREQ-1:0]             o_grant,
  output logic                          o_busy,
  output logic                          o_abort
);

  localparam int IDXW = $clog2(clamp_int(c_NREQ, NREQ_MIN, NREQ_MAX));
  localparam int TIMEOUT = clamp_int(c_TIMEOUT, TIMEOUT_MIN, TIMEOUT_MAX);
  localparam logic [IDLECNT_W-1:0] IDLE_LIMIT = IDLECNT_W'(TIMEOUT - 1);

  arb_state_t           r_state;
  logic [IDXW-1:0]      r_grant;
  logic [IDXW-1:0]      r_lastgrant;
  logic [IDLECNT_W-1:0] r_idlecnt;

  logic [c_NREQ-1:0] pick_oh;
  logic              pick_found;
  logic              pick_allow;
  logic [IDXW-1:0]   pick_idx;
  logic              g_valid;
  logic              g_last;
  logic              xfer;

  rr_pick #(
    .NREQ (c_NREQ),
    .IDXW (IDXW)
  ) u_rr_pick (
    .req   (i_req_valid),
    .last  (r_lastgrant),
    .pick  (pick_oh),
    .found (pick_found)
  );

  assign pick_idx   = IDXW'(oh_index(NREQ_MAX'(pick_oh)));
  assign pick_allow = pick_found && ((c_GATE_NEARFULL == 0) || !i_fifo_nearfull);

  // Owner's byte is passed straight through; ready only ever goes to the owner.
  always_comb begin
    o_fifo_data = '0;
    g_valid     = 1'b0;
    g_last      = 1'b0;
    o_req_ready = '0;
    for (int k = 0; k < c_NREQ; k++) begin
      if (r_grant == IDXW'(k)) begin
        o_fifo_data    = i_req_data[k*c_DATAWIDTH +: c_DATAWIDTH];
        g_valid        = i_req_valid[k];
        g_last         = i_req_last[k];
        o_req_ready[k] = (r_state == ST_LOCK) && !i_fifo_full;
      end
    end
  end

  assign xfer           = (r_state == ST_LOCK) && g_valid && !i_fifo_full;
  assign o_fifo_writeen = xfer;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_lastgrant <= IDXW'(c_NREQ - 1);
      r_idlecnt   <= '0;
      o_grant     <= '0;
      o_busy      <= 1'b0;
      o_abort     <= 1'b0;
    end else begin
      o_abort <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (pick_allow) begin
          r_state <= ST_LOCK;
          r_grant <= pick_idx;
          o_grant <= pick_oh;
          o_busy  <= 1'b1;
        end
      end else if (xfer) begin
        r_idlecnt <= '0;
        if (g_last) begin
          r_state     <= ST_IDLE;
          r_lastgrant <= r_grant;
          o_grant     <= '0;
          o_busy      <= 1'b0;
        end
      end else if (!g_valid) begin
        // Only a silent owner ages; a full FIFO with valid held leaves the count alone.
        if (r_idlecnt == IDLE_LIMIT) begin
          r_state     <= ST_IDLE;
          r_lastgrant <= r_grant;
          r_idlecnt   <= '0;
          o_grant     <= '0;
          o_busy      <= 1'b0;
          o_abort     <= 1'b1;
        end else if (r_idlecnt != '1) begin
          r_idlecnt <= r_idlecnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - randomized bench for fifo_write_arbiter against a cycle reference model
module tb_fifo_write_arbiter;

  localparam int NREQ = 2;
  localparam int W    = 8;
  localparam int TMO  = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req_valid, req_last, req_ready, grant;
  logic [NREQ*W-1:0] req_data;
  logic            we, full, nearfull, busy, abort_o;
  logic [W-1:0]    fdata;

  always #5 clk = ~clk;

  fifo_write_arbiter #(
    .c_NREQ(NREQ), .c_DATAWIDTH(W), .c_TIMEOUT(TMO), .c_GATE_NEARFULL(1)
  ) dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_req_valid(req_valid), .i_req_last(req_last), .i_req_data(req_data),
    .o_req_ready(req_ready), .o_fifo_writeen(we), .o_fifo_data(fdata),
    .i_fifo_full(full), .i_fifo_nearfull(nearfull),
    .o_grant(grant), .o_busy(busy), .o_abort(abort_o)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model: owner index (-1 = nobody), last winner, consecutive silent cycles
  int m_owner, m_last, m_idle;
  bit m_abort;

  // producers and scoreboard
  logic [8:0] byte_q [NREQ][$];
  logic [7:0] sent_q [NREQ][$];
  bit         pres [NREQ];
  int         gap_pct = 0;
  bit         rand_full = 0, full_force = 0, nf_force = 0;
  int         wr_cyc[$], wr_src[$], abort_cyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = NREQ - 1; m_idle = 0; m_abort = 0;
  endtask

  task automatic drive();
    for (int k = 0; k < NREQ; k++) begin
      if (!pres[k] && byte_q[k].size() > 0 && $urandom_range(99) >= gap_pct) pres[k] = 1;
      req_valid[k] = pres[k];
      if (byte_q[k].size() > 0) begin
        req_last[k]        = byte_q[k][0][8];
        req_data[k*W +: W] = byte_q[k][0][7:0];
      end else begin
        req_last[k]        = 1'b0;
        req_data[k*W +: W] = '0;
      end
    end
    full     = full_force | (rand_full && ($urandom_range(99) < 20));
    nearfull = nf_force   | (rand_full && ($urandom_range(99) < 20));
  endtask

  task automatic push_byte(input int k, input logic [7:0] d, input bit last);
    byte_q[k].push_back({last, d});
    sent_q[k].push_back(d);
  endtask

  task automatic push_pkt(input int k, input int n);
    for (int i = 0; i < n; i++) push_byte(k, 8'($urandom_range(255)), i == n - 1);
  endtask

  task automatic cycle();
    int nxt_owner, g, xk, src;
    bit nxt_abort, e_we;
    logic [NREQ-1:0] e_ready, e_grant;
    @(negedge clk);
    e_grant = '0;
    if (m_owner >= 0) e_grant[m_owner] = 1'b1;
    chk("grant", grant, e_grant);
    chk("busy", busy, m_owner >= 0);
    chk("abort", abort_o, m_abort);
    nxt_owner = m_owner; nxt_abort = 0; e_ready = '0; e_we = 0; xk = -1; g = 0;
    if (m_owner < 0) begin
      if (!nearfull) begin
        for (int i = 1; i <= NREQ; i++) begin
          if (nxt_owner < 0 && req_valid[(m_last + i) % NREQ]) nxt_owner = (m_last + i) % NREQ;
        end
      end
      m_idle = 0;
    end else begin
      g = m_owner;
      e_ready[g] = !full;
      e_we = req_valid[g] && !full;
      if (e_we) begin
        xk = g; m_idle = 0;
        if (req_last[g]) begin nxt_owner = -1; m_last = g; end
      end else if (!req_valid[g]) begin
        m_idle++;
        if (m_idle == TMO) begin nxt_owner = -1; m_last = g; m_idle = 0; nxt_abort = 1; end
      end
    end
    chk("ready", req_ready, e_ready);
    chk("we", we, e_we);
    if (e_we) chk("data", fdata, req_data[g*W +: W]);
    if (we) begin
      src = -1;
      for (int k = 0; k < NREQ; k++) if (grant[k]) src = k;
      if (src >= 0) begin
        if (sent_q[src].size() == 0) chk("sb_extra_wr", we, 0);
        else chk("sb_data", fdata, sent_q[src].pop_front());
        wr_cyc.push_back(cyc); wr_src.push_back(src);
      end
    end
    if (abort_o) abort_cyc.push_back(cyc);
    @(posedge clk); #1;
    cyc++;
    m_owner = nxt_owner; m_abort = nxt_abort;
    if (xk >= 0) begin void'(byte_q[xk].pop_front()); pres[xk] = 0; end
    drive();
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((m_owner >= 0 || byte_q[0].size() > 0 || byte_q[1].size() > 0) && n < bound) begin
      cycle(); n++;
    end
    chk("drain_left", byte_q[0].size() + byte_q[1].size(), 0);
  endtask

  task automatic wait_writes(input int target, input int bound);
    int n = 0;
    while (wr_src.size() < target && n < bound) begin cycle(); n++; end
    chk("wait_writes", wr_src.size() >= target, 1);
  endtask

  initial begin
    int s, a0;
    rst_n = 0; req_valid = '0; req_last = '0; req_data = '0; full = 0; nearfull = 0;
    for (int k = 0; k < NREQ; k++) pres[k] = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_grant", grant, 0); chk("rst_busy", busy, 0); chk("rst_abort", abort_o, 0);
    chk("rst_ready", req_ready, 0); chk("rst_we", we, 0);
    drive();

    // single 3-byte packet from requester 0
    s = wr_src.size();
    push_byte(0, 8'h11, 0); push_byte(0, 8'h22, 0); push_byte(0, 8'h33, 1);
    drive(); drain(40);
    chk("p1_count", wr_src.size() - s, 3);
    if (wr_src.size() - s == 3) begin
      chk("p1_contig_a", wr_cyc[s+1] - wr_cyc[s], 1);
      chk("p1_contig_b", wr_cyc[s+2] - wr_cyc[s+1], 1);
    end

    // near-full holds off a new grant to requester 1
    nf_force = 1; push_pkt(1, 2); drive();
    repeat (6) cycle();
    chk("nf_hold", grant, 0);
    nf_force = 0; drive();
    cycle();
    chk("nf_grant", grant, 2'b10);
    drain(40);

    // both requesters at once: 0 first, then 1, no interleave
    s = wr_src.size();
    push_pkt(0, 4); push_pkt(1, 4); drive(); drain(80);
    chk("p2_count", wr_src.size() - s, 8);
    if (wr_src.size() - s == 8) begin
      for (int i = 0; i < 8; i++) chk("p2_order", wr_src[s+i], (i < 4) ? 0 : 1);
    end
    chk("p2_lastgrant", dut.r_lastgrant, 1);

    // full for 10 cycles mid-packet
    s = wr_src.size(); a0 = abort_cyc.size();
    push_pkt(0, 6); drive();
    wait_writes(s + 2, 40);
    full_force = 1; drive();
    repeat (10) cycle();
    chk("full_nowr", wr_src.size() - s, 2);
    full_force = 0; drive(); drain(60);
    chk("full_count", wr_src.size() - s, 6);
    chk("full_noabort", abort_cyc.size() - a0, 0);

    // stalled owner times out, pending requester 1 takes over
    s = wr_src.size(); a0 = abort_cyc.size();
    push_byte(0, 8'hA1, 0); push_byte(0, 8'hA2, 0); drive();
    wait_writes(s + 2, 40);
    push_pkt(1, 3); drive(); drain(60);
    chk("to_abort_n", abort_cyc.size() - a0, 1);
    chk("to_count", wr_src.size() - s, 5);
    if (abort_cyc.size() - a0 == 1 && wr_src.size() - s == 5) begin
      chk("to_delay", abort_cyc[a0] - wr_cyc[s+1], TMO + 1);
      chk("to_src0", wr_src[s+1], 0);
      chk("to_next", wr_src[s+2], 1);
    end
    sent_q[0].delete();

    // asynchronous reset mid-packet
    s = wr_src.size();
    push_pkt(0, 5); drive();
    wait_writes(s + 1, 40);
    @(negedge clk); #2 rst_n = 0;
    #1;
    chk("arst_grant", grant, 0); chk("arst_busy", busy, 0); chk("arst_ready", req_ready, 0);
    model_reset();
    for (int k = 0; k < NREQ; k++) begin byte_q[k].delete(); sent_q[k].delete(); pres[k] = 0; end
    drive();
    @(posedge clk); @(posedge clk); #1 rst_n = 1;
    s = wr_src.size();
    push_pkt(1, 2); push_pkt(0, 2); drive(); drain(40);
    chk("arst_count", wr_src.size() - s, 4);
    if (wr_src.size() - s == 4) chk("arst_prio", wr_src[s], 0);

    // random traffic with gaps, backpressure and near-full
    gap_pct = 30; rand_full = 1;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(99) < 20) begin
        int k;
        k = $urandom_range(NREQ - 1);
        if (byte_q[k].size() < 8) push_pkt(k, $urandom_range(1, 5));
      end
      cycle();
    end
    gap_pct = 0; rand_full = 0; drive(); drain(500);
    chk("rand_sb0", sent_q[0].size(), 0);
    chk("rand_sb1", sent_q[1].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
